// File: rtl/tnn_pkg.sv
// tnn_pkg: shared widths, beat types and packer state encoding for the TNN datapath
package tnn_pkg;
  localparam int TNN_WORD_W = 64;
  localparam int TNN_BEAT_W = 512;
  localparam int TNN_LANES = 8;
  typedef logic [TNN_WORD_W-1:0] tnn_word_t;
  typedef logic [TNN_BEAT_W-1:0] tnn_beat_t;
  typedef logic [TNN_LANES-1:0] tnn_keep_t;
  typedef enum logic [1:0] {EMPTY, FILL, HOLD} pack_state_e;
endpackage

// File: rtl/tnn_beat_reg.sv
// tnn_beat_reg: single-entry beat output register, holds its contents until the consumer takes it
module tnn_beat_reg
  import tnn_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [TNN_BEAT_W-1:0] i_bits,
  input  logic [TNN_LANES-1:0]  i_keep,
  input  logic                  i_last,
  input  logic                  i_rdy,
  output logic [TNN_BEAT_W-1:0] o_bits,
  output logic [TNN_LANES-1:0]  o_keep,
  output logic                  o_last,
  output logic                  o_vld,
  output logic                  o_free
);
  assign o_free = !o_vld | i_rdy;
  // load a new beat when asked, otherwise drop valid once the consumer accepts
  always_ff @(posedge clk) begin
    if (rst) begin
      o_bits <= '0;
      o_keep <= '0;
      o_last <= 1'b0;
      o_vld <= 1'b0;
    end else if (i_load) begin
      o_bits <= i_bits;
      o_keep <= i_keep;
      o_last <= i_last;
      o_vld <= 1'b1;
    end else if (i_rdy) begin
      o_vld <= 1'b0;
    end
  end
endmodule

// File: rtl/tnn_res_packer_64_to_512.sv
// tnn_res_packer_64_to_512: packs 64-bit result words into 512-bit beats; optional idle flush via TNN_PACK_TIMEOUT_FLUSH_EN
module tnn_res_packer_64_to_512
  import tnn_pkg::*;
#(
  parameter int WORD_W = 64,
  parameter int LANES = 8,
  parameter int FLUSH_TIMEOUT = 256
) (
  input  logic                      clk_a1,
  input  logic                      srst,
  input  logic [WORD_W-1:0]         s_bits,
  input  logic                      s_vld,
  input  logic                      s_last,
  output logic                      s_rdy,
  output logic [WORD_W*LANES-1:0]   m_bits,
  output logic [LANES-1:0]          m_keep,
  output logic                      m_last,
  output logic                      m_vld,
  input  logic                      m_rdy,
  output logic [31:0]               frame_cnt
);
  pack_state_e r_state;
  tnn_beat_t r_acc;
  tnn_keep_t r_keep;
  logic [2:0] r_cnt;
  logic r_hlast;
  logic w_acc_ok, w_free, w_hold, w_done, w_load, w_flush, w_last_n;
  tnn_beat_t w_acc_n;
  tnn_keep_t w_keep_n;
  assign w_acc_ok = s_vld & s_rdy;
  assign w_hold = r_state == HOLD;
  assign w_acc_n = w_acc_ok ? (r_acc | (tnn_beat_t'(s_bits) << {r_cnt, 6'd0})) : r_acc;
  assign w_keep_n = w_acc_ok ? (r_keep | (tnn_keep_t'(1) << r_cnt)) : r_keep;
  assign w_last_n = w_hold ? r_hlast : (w_acc_ok & s_last);
  assign w_done = !w_hold & ((w_acc_ok & ((r_cnt == 3'(LANES - 1)) | s_last)) | w_flush);
  assign w_load = w_free & (w_hold | w_done);
`ifdef TNN_PACK_TIMEOUT_FLUSH_EN
  logic [15:0] r_idle;
  assign w_flush = (r_state == FILL) && (r_idle == 16'(FLUSH_TIMEOUT));
  always_ff @(posedge clk_a1) begin
    if (srst | w_acc_ok | w_flush) r_idle <= '0;
    else if (r_state == FILL && !s_vld) r_idle <= r_idle + 16'd1;
  end
`else
  assign w_flush = 1'b0;
`endif
  always_ff @(posedge clk_a1) begin
    if (srst) begin
      r_state <= EMPTY;
      r_acc <= '0;
      r_keep <= '0;
      r_cnt <= '0;
      r_hlast <= 1'b0;
      s_rdy <= 1'b0;
    end else begin
      s_rdy <= !(w_hold | w_done) | w_free;
      if (w_load) begin
        r_state <= EMPTY;
        r_acc <= '0;
        r_keep <= '0;
        r_cnt <= '0;
        r_hlast <= 1'b0;
      end else if (w_done) begin
        r_state <= HOLD;
        r_acc <= w_acc_n;
        r_keep <= w_keep_n;
        r_hlast <= w_last_n;
      end else if (w_acc_ok) begin
        r_state <= FILL;
        r_acc <= w_acc_n;
        r_keep <= w_keep_n;
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end
  always_ff @(posedge clk_a1) begin
    if (srst) frame_cnt <= '0;
    else if (m_vld & m_rdy & m_last) frame_cnt <= frame_cnt + 32'd1;
  end
  tnn_beat_reg u_out (
    .clk(clk_a1),
    .rst(srst),
    .i_load(w_load),
    .i_bits(w_acc_n),
    .i_keep(w_keep_n),
    .i_last(w_last_n),
    .i_rdy(m_rdy),
    .o_bits(m_bits),
    .o_keep(m_keep),
    .o_last(m_last),
    .o_vld(m_vld),
    .o_free(w_free)
  );
endmodule
